// File: rtl/icap_arbiter_pkg.sv
// Shared definitions for the two-requester ICAP arbiter: FSM encoding and the
// fixed sync/desync command words framed around every granted payload.
package icap_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_HEADER  = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_TRAILER = 2'd3
   } state_e;

   localparam int HDR_LEN = 3;
   localparam int TRL_LEN = 4;

   localparam logic [31:0] ICAP_DUMMY  = 32'hFFFF_FFFF;
   localparam logic [31:0] ICAP_SYNC   = 32'hAA99_5566;
   localparam logic [31:0] ICAP_NOOP   = 32'h2000_0000;
   localparam logic [31:0] ICAP_CMD_WR = 32'h3000_8001;
   localparam logic [31:0] ICAP_DESYNC = 32'h0000_000D;

   function automatic logic [31:0] hdr_word(input logic [1:0] idx);
      case (idx)
         2'd0:    return ICAP_DUMMY;
         2'd1:    return ICAP_SYNC;
         default: return ICAP_NOOP;
      endcase
   endfunction

   function automatic logic [31:0] trl_word(input logic [1:0] idx);
      case (idx)
         2'd0:    return ICAP_CMD_WR;
         2'd1:    return ICAP_DESYNC;
         default: return ICAP_NOOP;
      endcase
   endfunction

endpackage

// File: rtl/icap_rr_pick.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the
// requester that was not granted last time.
module icap_rr_pick
   import icap_arbiter_pkg::*;
(
   input  logic       valid0_i,
   input  logic       valid1_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = 2'b00;
      if (valid0_i && valid1_i) begin
         grant_o = last_grant_i ? 2'b01 : 2'b10;
      end else if (valid0_i) begin
         grant_o = 2'b01;
      end else if (valid1_i) begin
         grant_o = 2'b10;
      end
   end

endmodule

// File: rtl/icap_arbiter.sv
// Arbitrates two configuration requesters onto one ICAP port, wrapping each
// granted payload in a sync header and a desync trailer.
module icap_arbiter
   import icap_arbiter_pkg::*;
#(
   parameter int ICAP_DATA_SIZE = 32,
   parameter int FLAG_SIZE      = 1,
   parameter int STALL_LIMIT    = 255
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic [FLAG_SIZE-1:0]      req0_valid,
   input  logic [ICAP_DATA_SIZE-1:0] req0_data,
   input  logic [FLAG_SIZE-1:0]      req0_last,
   output logic [FLAG_SIZE-1:0]      req0_ready,
   input  logic [FLAG_SIZE-1:0]      req1_valid,
   input  logic [ICAP_DATA_SIZE-1:0] req1_data,
   input  logic [FLAG_SIZE-1:0]      req1_last,
   output logic [FLAG_SIZE-1:0]      req1_ready,
   output logic                      icap_csib,
   output logic                      icap_rdwrb,
   output logic [ICAP_DATA_SIZE-1:0] icap_data,
   output logic [1:0]                grant,
   output logic                      done,
   output logic                      abort,
   output logic [1:0]                dbg_state
);

   state_e                    state_q, state_d;
   logic [1:0]                idx_q, idx_d;
   logic [1:0]                grant_q, grant_d;
   logic                      last_grant_q, last_grant_d;
   logic [7:0]                stall_q, stall_d;
   logic                      abort_flag_q, abort_flag_d;
   logic [ICAP_DATA_SIZE-1:0] data_q, data_d;

   logic [1:0]                pick;
   logic                      sel_valid, sel_last;
   logic [ICAP_DATA_SIZE-1:0] sel_data;
   logic                      csib_c, rdy0_c, rdy1_c, done_c, abort_c;

   icap_rr_pick u_pick (
      .valid0_i     (req0_valid[0]),
      .valid1_i     (req1_valid[0]),
      .last_grant_i (last_grant_q),
      .grant_o      (pick)
   );

   // A word transfers in any cycle where the granted requester has valid and
   // ready both high; it appears on icap_data in that same cycle.
   assign sel_valid = grant_q[1] ? req1_valid[0] : req0_valid[0];
   assign sel_last  = grant_q[1] ? req1_last[0]  : req0_last[0];
   assign sel_data  = grant_q[1] ? req1_data     : req0_data;

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      stall_d      = stall_q;
      abort_flag_d = abort_flag_q;
      data_d       = data_q;
      csib_c       = 1'b1;
      rdy0_c       = 1'b0;
      rdy1_c       = 1'b0;
      done_c       = 1'b0;
      abort_c      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick != 2'b00) begin
               grant_d      = pick;
               last_grant_d = pick[1];
               state_d      = ST_HEADER;
               idx_d        = 2'd0;
            end
         end
         ST_HEADER: begin
            csib_c = 1'b0;
            data_d = ICAP_DATA_SIZE'(hdr_word(idx_q));
            if (idx_q == 2'(HDR_LEN - 1)) begin
               state_d      = ST_PAYLOAD;
               idx_d        = 2'd0;
               stall_d      = 8'd0;
               abort_flag_d = 1'b0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         ST_PAYLOAD: begin
            rdy0_c = grant_q[0];
            rdy1_c = grant_q[1];
            if (sel_valid) begin
               csib_c  = 1'b0;
               data_d  = sel_data;
               stall_d = 8'd0;
               if (sel_last) begin
                  state_d = ST_TRAILER;
                  idx_d   = 2'd0;
               end
            end else begin
               // A handshake in the limit cycle would have taken the branch above.
               stall_d = stall_q + 8'd1;
               if ((stall_q + 8'd1) == 8'(STALL_LIMIT)) begin
                  state_d      = ST_TRAILER;
                  idx_d        = 2'd0;
                  abort_flag_d = 1'b1;
               end
            end
         end
         ST_TRAILER: begin
            csib_c = 1'b0;
            data_d = ICAP_DATA_SIZE'(trl_word(idx_q));
            if (idx_q == 2'(TRL_LEN - 1)) begin
               done_c  = ~abort_flag_q;
               abort_c = abort_flag_q;
               state_d = ST_IDLE;
               grant_d = 2'b00;
               idx_d   = 2'd0;
            end else begin
               idx_d = idx_q + 2'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         idx_q        <= 2'd0;
         grant_q      <= 2'b00;
         last_grant_q <= 1'b1;
         stall_q      <= 8'd0;
         abort_flag_q <= 1'b0;
         data_q       <= '0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         stall_q      <= stall_d;
         abort_flag_q <= abort_flag_d;
         data_q       <= data_d;
      end
   end

   assign req0_ready = FLAG_SIZE'(rdy0_c);
   assign req1_ready = FLAG_SIZE'(rdy1_c);
   assign icap_csib  = csib_c;
   assign icap_rdwrb = 1'b0;
   assign icap_data  = data_d;
   assign grant      = grant_q;
   assign done       = done_c;
   assign abort      = abort_c;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_icap_arbiter.sv
// Bench for icap_arbiter: expected ICAP word stream and owner per transaction
// come from a queue model built from the framing and round-robin rules.
module tb_icap_arbiter;

   localparam int STALL_LIMIT = 255;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req0_valid, req0_last, req0_ready;
   logic        req1_valid, req1_last, req1_ready;
   logic [31:0] req0_data, req1_data;
   logic        icap_csib, icap_rdwrb, done, abort;
   logic [31:0] icap_data;
   logic [1:0]  grant, dbg_state;

   always #5 clock = ~clock;

   icap_arbiter #(.ICAP_DATA_SIZE(32), .FLAG_SIZE(1), .STALL_LIMIT(STALL_LIMIT)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(req1_ready),
      .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_data(icap_data),
      .grant(grant), .done(done), .abort(abort), .dbg_state(dbg_state)
   );

   logic [31:0] hdr_w [3] = '{32'hFFFFFFFF, 32'hAA995566, 32'h20000000};
   logic [31:0] trl_w [4] = '{32'h30008001, 32'h0000000D, 32'h20000000, 32'h20000000};

   int          n_tests, n_fail;
   logic [31:0] exp_q[$];
   logic [31:0] tx_words[$];
   logic [31:0] words_q[$];
   logic [31:0] prev_word;
   logic [1:0]  exp_grant;
   bit          last_w, w, want_loser, exp_abort, fin;
   int          n_hs, cyc, first_cs, stall_done, gap_mode, stall_at, stall_len;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      assert (act === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_grant"}, grant, 2'b00);
      chk({tag, "_csib"}, icap_csib, 1'b1);
      chk({tag, "_rdwrb"}, icap_rdwrb, 1'b0);
      chk({tag, "_data"}, icap_data, 32'h0);
      chk({tag, "_ready0"}, req0_ready, 1'b0);
      chk({tag, "_ready1"}, req1_ready, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_abort"}, abort, 1'b0);
   endtask

   // Winner presents its words in order, optionally with gaps; the loser just
   // holds valid high with junk until the transaction is over.
   task automatic drive_inputs();
      bit          gap, vw, vl, lw;
      logic [31:0] dw;
      gap = 1'b0;
      if (n_hs >= 1) begin
         if (gap_mode == 1) gap = ($urandom_range(0, 3) == 0);
         if (gap_mode == 2) gap = cyc[0];
         if (n_hs == stall_at && stall_done < stall_len) gap = 1'b1;
      end
      vw = !fin && (n_hs < words_q.size()) && !gap;
      dw = (n_hs < words_q.size()) ? words_q[n_hs] : $urandom;
      lw = (n_hs == words_q.size() - 1);
      vl = !fin && want_loser;
      if (w) begin
         req1_valid = vw; req1_data = dw; req1_last = lw;
         req0_valid = vl; req0_data = $urandom; req0_last = 1'($urandom_range(0, 1));
      end else begin
         req0_valid = vw; req0_data = dw; req0_last = lw;
         req1_valid = vl; req1_data = $urandom; req1_last = 1'($urandom_range(0, 1));
      end
   endtask

   task automatic check_cycle();
      logic        rdy_w, rdy_l, vw;
      logic [31:0] exp_w;
      rdy_w = w ? req1_ready : req0_ready;
      rdy_l = w ? req0_ready : req1_ready;
      vw    = w ? req1_valid : req0_valid;
      chk("rdwrb", icap_rdwrb, 1'b0);
      chk("loser_ready", rdy_l, 1'b0);
      chk("grant", grant, (cyc == 0) ? 2'b00 : exp_grant);
      if (cyc == 0) chk("idle_ready", rdy_w, 1'b0);
      if (icap_csib === 1'b0) begin
         if (first_cs < 0) first_cs = cyc;
         if (exp_q.size() == 0) begin
            chk("extra_word_csib", icap_csib, 1'b1);
         end else begin
            exp_w = exp_q.pop_front();
            chk("word", icap_data, exp_w);
            prev_word = exp_w;
            if (exp_q.size() == 0) begin
               chk("done", done, !exp_abort);
               chk("abort", abort, exp_abort);
               fin = 1'b1;
            end else begin
               chk("early_done_abort", {done, abort}, 2'b00);
            end
         end
      end else begin
         chk("gap_done_abort", {done, abort}, 2'b00);
         if (rdy_w && !vw) begin
            chk("gap_hold", icap_data, prev_word);
            if (n_hs == stall_at) stall_done++;
         end
      end
      if (rdy_w && vw) n_hs++;
   endtask

   task automatic run_txn(input bit want0, input bit want1, input int gap_i,
                          input int stall_at_i, input int stall_len_i);
      int n_send;
      words_q   = tx_words;
      gap_mode  = gap_i;
      stall_at  = stall_at_i;
      stall_len = stall_len_i;
      if (want0 && want1) w = !last_w;
      else                w = want1;
      want_loser = w ? want0 : want1;
      last_w     = w;
      exp_grant  = w ? 2'b10 : 2'b01;
      exp_abort  = (stall_at >= 1) && (stall_at < words_q.size()) && (stall_len >= STALL_LIMIT);
      n_send     = exp_abort ? stall_at : words_q.size();
      exp_q.delete();
      foreach (hdr_w[i]) exp_q.push_back(hdr_w[i]);
      for (int i = 0; i < n_send; i++) exp_q.push_back(words_q[i]);
      foreach (trl_w[i]) exp_q.push_back(trl_w[i]);
      n_hs = 0; cyc = 0; fin = 1'b0; first_cs = -1; stall_done = 0;
      drive_inputs();
      while (!fin && cyc < 1000) begin
         @(negedge clock);
         check_cycle();
         @(posedge clock); #1;
         cyc++;
         drive_inputs();
      end
      chk("txn_complete", fin, 1'b1);
      chk("hdr_latency", first_cs, 1);
      chk("stall_cycles", stall_done,
          exp_abort ? STALL_LIMIT : ((stall_at >= 1 && stall_at < words_q.size()) ? stall_len : 0));
      @(negedge clock);
      chk("end_grant", grant, 2'b00);
      chk("end_csib", icap_csib, 1'b1);
      @(posedge clock); #1;
   endtask

   initial begin
      bit seen;
      int cnt, r, len;
      n_tests = 0; n_fail = 0; last_w = 1'b1; prev_word = 32'h0; w = 1'b0;
      req0_valid = 0; req0_data = 0; req0_last = 0;
      req1_valid = 0; req1_data = 0; req1_last = 0;
      repeat (3) @(posedge clock);
      #1;
      check_reset("rst");
      reset = 1'b1;

      // Tie right at reset release: req0 first, then alternating.
      tx_words = '{32'h11111111, 32'h22222222};
      run_txn(1, 1, 0, -1, 0);
      tx_words = '{32'hA0000001, 32'hA0000002, 32'hA0000003};
      run_txn(1, 1, 0, -1, 0);
      tx_words = '{32'hB0000001};
      run_txn(1, 1, 0, -1, 0);

      // req1 alone with valid toggling every other cycle.
      tx_words = '{32'hC0000001, 32'hC0000002, 32'hC0000003, 32'hC0000004, 32'hC0000005};
      run_txn(0, 1, 2, -1, 0);

      // One cycle short of the stall limit: no abort.
      tx_words = '{32'hD0000001, 32'hD0000002, 32'hD0000003};
      run_txn(1, 0, 0, 1, STALL_LIMIT - 1);

      // Full stall: trailer, abort pulse, no done.
      tx_words = '{32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004};
      run_txn(1, 0, 0, 2, STALL_LIMIT + 40);

      for (int t = 0; t < 8; t++) begin
         r   = $urandom_range(1, 3);
         len = $urandom_range(1, 6);
         tx_words.delete();
         for (int i = 0; i < len; i++) tx_words.push_back($urandom);
         run_txn(r[0], r[1], $urandom_range(0, 1), -1, 0);
      end

      // Reset during payload, then a fresh tie must start with the full header.
      w = 1'b0;
      req0_valid = 1; req0_data = 32'h5A5A0001; req0_last = 0; req1_valid = 0;
      seen = 1'b0; cnt = 0;
      while (!seen && cnt < 20) begin
         @(negedge clock);
         if (req0_ready === 1'b1) seen = 1'b1;
         else begin
            @(posedge clock); #1;
         end
         cnt++;
      end
      chk("mid_payload_reached", seen, 1'b1);
      #2 reset = 1'b0;
      #1 check_reset("mid_rst");
      req0_valid = 0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
      last_w = 1'b1; prev_word = 32'h0;
      tx_words = '{32'h77770001, 32'h77770002};
      run_txn(1, 1, 0, -1, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
